// File: rtl/shift_reg_univ_seq.sv
// Universal shift/rotate register that performs a counted multi-step operation,
// one step per clock, with parallel load, abort and a one-cycle completion pulse.
module shift_reg_univ_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] I_i,
    input  logic             ld_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             sin_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] A_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [1:0] MODE_SHL  = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_ROTL = 2'b10;
    localparam logic [1:0] MODE_ROTR = 2'b11;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] stepA;
    logic             stepSout;

    // One step of the latched operation, evaluated from the current register value.
    always_comb begin
        stepA    = a_q;
        stepSout = sout_q;
        case (mode_q)
            MODE_SHL: begin
                stepA    = {a_q[WIDTH-2:0], sin_i};
                stepSout = a_q[WIDTH-1];
            end
            MODE_SHR: begin
                stepA    = {sin_i, a_q[WIDTH-1:1]};
                stepSout = a_q[0];
            end
            MODE_ROTL: begin
                stepA    = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
                stepSout = a_q[WIDTH-1];
            end
            MODE_ROTR: begin
                stepA    = {a_q[0], a_q[WIDTH-1:1]};
                stepSout = a_q[0];
            end
            default: begin
                stepA    = a_q;
                stepSout = sout_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_i) begin
                    a_d = I_i;
                end else if (start_i) begin
                    // A zero-length request completes immediately without visiting SHIFT.
                    if (cnt_i != '0) begin
                        mode_d  = mode_i;
                        cnt_d   = cnt_i;
                        state_d = ST_SHIFT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    a_d    = stepA;
                    sout_d = stepSout;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            sout_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_SHL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign A_o    = a_q;
    assign sout_o = sout_q;
    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = done_q;

endmodule

// File: doc/shift_reg_univ_seq.md
SHIFT_REG_UNIV_SEQ -- requirements
Module: shift_reg_univ_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (>=2).
REQ-002 The block SHALL have parameter CNT_W, default 4, shift-count width in bits (>=1).
REQ-003 The block SHALL have port clk_i  input  1  sole clock, rising-edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port I_i  input  WIDTH  parallel load data.
REQ-006 The block SHALL have port ld_i  input  1  parallel load request.
REQ-007 The block SHALL have port start_i  input  1  start multi-step shift.
REQ-008 The block SHALL have port mode_i  input  2  shift mode: 00 shl, 01 shr, 10 rotl, 11 rotr.
REQ-009 The block SHALL have port cnt_i  input  CNT_W  number of steps.
REQ-010 The block SHALL have port sin_i  input  1  serial fill bit for shl/shr.
REQ-011 The block SHALL have port abort_i  input  1  cancel an operation in progress.
REQ-012 The block SHALL have port A_o  output  WIDTH  register contents.
REQ-013 The block SHALL have port sout_o  output  1  last bit shifted or rotated out, registered.
REQ-014 The block SHALL have port busy_o  output  1  high while in SHIFT.
REQ-015 The block SHALL have port done_o  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have two states: IDLE and SHIFT. busy_o SHALL equal (state==SHIFT).
REQ-017 In IDLE with ld_i=1, the edge SHALL set A_o<=I_i. ld_i SHALL take priority over start_i, and a simultaneous start_i SHALL be dropped.
REQ-018 In IDLE with ld_i=0, start_i=1 and cnt_i=N>0, the edge SHALL latch mode_i and N into internal registers and enter SHIFT; A_o SHALL be unchanged on that edge.
REQ-019 In IDLE with ld_i=0, start_i=1 and cnt_i=0, the edge SHALL leave A_o unchanged, stay in IDLE, and assert done_o for the next cycle.
REQ-020 In SHIFT with abort_i=0, each edge SHALL perform exactly one step using the latched mode and decrement the remaining count.
- shl: A<={A[W-2:0],sin_i}, sout<=A[W-1]
- shr: A<={sin_i,A[W-1:1]}, sout<=A[0]
- rotl: A<={A[W-2:0],A[W-1]}, sout<=A[W-1]
- rotr: A<={A[0],A[W-1:1]}, sout<=A[0]
REQ-021 sin_i SHALL be sampled on every shl/shr step edge and SHALL be ignored for rotates.
REQ-022 On the edge where the remaining count goes 1->0, the block SHALL perform the step, go to IDLE and set done_o=1 for exactly one cycle. busy_o SHALL be high for exactly N cycles.
REQ-023 N greater than WIDTH SHALL be legal. Rotates SHALL wrap modulo WIDTH. shl/shr SHALL fill the whole register with successive sin_i values.
REQ-024 In SHIFT, abort_i=1 SHALL take priority over the step: no shift, A_o and sout_o hold, go to IDLE, and done_o stays 0.
REQ-025 In SHIFT, ld_i, start_i, mode_i and cnt_i SHALL be ignored.
REQ-026 In IDLE without an accepted ld_i, A_o and sout_o SHALL hold.
REQ-027 done_o SHALL be 0 in every cycle other than those defined in REQ-019 and REQ-022.
REQ-028 The next start_i SHALL be accepted in the cycle done_o is high (back-to-back operation).

Reset
REQ-029 rst_i=0 SHALL immediately force, asynchronously: A_o=0, sout_o=0, busy_o=0, done_o=0, state=IDLE, remaining count=0, latched mode=00.
REQ-030 A reset asserted mid-SHIFT SHALL discard the operation. No done_o SHALL follow the release of rst_i.
REQ-031 After release of rst_i, the first edge SHALL operate normally from IDLE.

Verification (WIDTH=8, CNT_W=4)
REQ-032 The bench SHALL cover: ld 0xA5, then start shl cnt=3 sin=1 -> A_o 0x4B, 0x97, 0x2F; sout_o 1, 0, 1; busy_o 3 cycles; done_o pulse once.
REQ-033 The bench SHALL cover: ld 0x81, rotr cnt=1 -> 0xC0; ld 0x81, rotr cnt=9 -> 0xC0 with busy_o 9 cycles.
REQ-034 The bench SHALL cover: start with cnt=0 on A_o=0x5A -> done_o high next cycle, busy_o never high, A_o=0x5A.
REQ-035 The bench SHALL cover: ld 0xF0, shr cnt=5 sin=0, abort_i before the 3rd step edge -> A_o=0x3C, busy_o drops, done_o never asserted.
REQ-036 The bench SHALL cover: ld_i=1 with I_i=0x3C and start_i=1 in the same IDLE cycle -> A_o=0x3C, busy_o stays 0.
REQ-037 The bench SHALL cover: rst_i low mid-SHIFT between clock edges -> all outputs 0 immediately; after release, ld 0x11 -> A_o=0x11.
